// File: rtl/bf2_sdf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage (one complex sample/clk).
// Ports: clk, rst (async high); in_valid/in_sync/in_re/in_im; out_valid/out_sync/out_re/out_im.
// Option macro BF2_SDF_SAT_EN: saturate instead of bit-drop when SCALE=0.
module bf2_sdf_stage #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 32,
  parameter int SCALE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sync,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             out_valid,
  output logic             out_sync,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im
);

  localparam int CW = $clog2(2 * DEPTH);
  localparam logic [CW-1:0] DIDX = CW'(DEPTH);

  // Reduce a (WIDTH+1)-bit sum/difference back to WIDTH bits.
  function automatic logic [WIDTH-1:0] fmt(input logic [WIDTH:0] s);
    logic [WIDTH-1:0] r;
    if (SCALE != 0) begin
      r = s[WIDTH:1];
    end else begin
`ifdef BF2_SDF_SAT_EN
      if (s[WIDTH] != s[WIDTH-1])
        r = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                     : {1'b0, {(WIDTH-1){1'b1}}};
      else
`endif
        r = {s[WIDTH], s[WIDTH-2:0]};
    end
    return r;
  endfunction

  logic [CW-1:0]    r_cnt;
  logic             r_primed;
  logic [WIDTH-1:0] r_dly_re [DEPTH];
  logic [WIDTH-1:0] r_dly_im [DEPTH];

  logic [CW-1:0]    w_idx;
  logic             w_bfly;
  logic             w_resync;
  logic             w_primed_n;
  logic [WIDTH-1:0] w_head_re;
  logic [WIDTH-1:0] w_head_im;
  logic [WIDTH:0]   w_sum_re;
  logic [WIDTH:0]   w_sum_im;
  logic [WIDTH:0]   w_dif_re;
  logic [WIDTH:0]   w_dif_im;
  logic [WIDTH-1:0] w_wr_re;
  logic [WIDTH-1:0] w_wr_im;
  logic [WIDTH-1:0] w_emit_re;
  logic [WIDTH-1:0] w_emit_im;

  // A sync sample is always index 0, whatever the counter says.
  assign w_idx     = in_sync ? '0 : r_cnt;
  assign w_bfly    = w_idx[CW-1];
  assign w_resync  = in_valid & in_sync & (r_cnt != '0);

  always_comb begin
    w_primed_n = r_primed;
    if (in_valid) begin
      if (w_resync)
        w_primed_n = 1'b0;
      else if (w_bfly)
        w_primed_n = 1'b1;
    end
  end

  assign w_head_re = r_dly_re[DEPTH-1];
  assign w_head_im = r_dly_im[DEPTH-1];

  assign w_sum_re = {w_head_re[WIDTH-1], w_head_re}
                  + {in_re[WIDTH-1], in_re};
  assign w_sum_im = {w_head_im[WIDTH-1], w_head_im}
                  + {in_im[WIDTH-1], in_im};
  assign w_dif_re = {w_head_re[WIDTH-1], w_head_re}
                  - {in_re[WIDTH-1], in_re};
  assign w_dif_im = {w_head_im[WIDTH-1], w_head_im}
                  - {in_im[WIDTH-1], in_im};

  assign w_wr_re   = w_bfly ? fmt(w_dif_re) : in_re;
  assign w_wr_im   = w_bfly ? fmt(w_dif_im) : in_im;
  assign w_emit_re = w_bfly ? fmt(w_sum_re) : w_head_re;
  assign w_emit_im = w_bfly ? fmt(w_sum_im) : w_head_im;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_primed <= 1'b0;
    end else if (in_valid) begin
      r_cnt    <= w_idx + 1'b1;
      r_primed <= w_primed_n;
    end
  end

  // Output data only moves when a valid sample is emitted, so it never
  // exposes unprimed delay contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sync  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      out_valid <= in_valid & w_primed_n;
      out_sync  <= in_valid & w_primed_n & (w_idx == DIDX);
      if (in_valid && w_primed_n) begin
        out_re <= w_emit_re;
        out_im <= w_emit_im;
      end
    end
  end

  // Delay line: head is read and entry 0 written in the same cycle.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_dly_re[0] <= w_wr_re;
      r_dly_im[0] <= w_wr_im;
      for (int i = 1; i < DEPTH; i++) begin
        r_dly_re[i] <= r_dly_re[i-1];
        r_dly_im[i] <= r_dly_im[i-1];
      end
    end
  end

endmodule

// File: tb/tb_bf2_sdf_stage.sv
// Bench for bf2_sdf_stage: three instances (D=4/S=0, D=1/S=0, D=1/S=1).
// Frame-level model with pair buffers; directed plan cases plus random traffic.
module tb_bf2_sdf_stage;

  localparam int W = 17;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_sync = 1'b0;
  logic [W-1:0] in_re = '0;
  logic [W-1:0] in_im = '0;
  logic         o_v  [3];
  logic         o_s  [3];
  logic [W-1:0] o_re [3];
  logic [W-1:0] o_im [3];

  always #5 clk = ~clk;

  bf2_sdf_stage #(.WIDTH(W), .DEPTH(4), .SCALE(0)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync),
    .in_re(in_re), .in_im(in_im), .out_valid(o_v[0]), .out_sync(o_s[0]),
    .out_re(o_re[0]), .out_im(o_im[0]));

  bf2_sdf_stage #(.WIDTH(W), .DEPTH(1), .SCALE(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync),
    .in_re(in_re), .in_im(in_im), .out_valid(o_v[1]), .out_sync(o_s[1]),
    .out_re(o_re[1]), .out_im(o_im[1]));

  bf2_sdf_stage #(.WIDTH(W), .DEPTH(1), .SCALE(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync),
    .in_re(in_re), .in_im(in_im), .out_valid(o_v[2]), .out_sync(o_s[2]),
    .out_re(o_re[2]), .out_im(o_im[2]));

  int n_chk = 0;
  int n_err = 0;

  // Model state per instance.
  int m_idx [3];
  bit m_pr  [3];
  int a_re  [3][8];
  int a_im  [3][8];
  int d_re  [3][8];
  int d_im  [3][8];
  bit e_v   [3];
  bit e_s   [3];
  int e_re  [3];
  int e_im  [3];

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int dep(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int fmt(int s, int k);
    int low;
    if (k == 2) return s >>> 1;
`ifdef BF2_SDF_SAT_EN
    if (s > 65535) return 65535;
    if (s < -65536) return -65536;
    return s;
`else
    low = s & 32'hFFFF;
    return (s < 0) ? low - 65536 : low;
`endif
  endfunction

  function automatic int sx(int v);
    logic [W-1:0] t;
    t = W'(v);
    return int'($signed(t));
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      m_idx[k] = 0; m_pr[k] = 1'b0;
      e_v[k] = 1'b0; e_s[k] = 1'b0; e_re[k] = 0; e_im[k] = 0;
      for (int i = 0; i < 8; i++) begin
        d_re[k][i] = 0; d_im[k][i] = 0;
      end
    end
  endtask

  task automatic m_step(bit v, bit s, int xr, int xi);
    int D, j, ore, oim;
    for (int k = 0; k < 3; k++) begin
      D = dep(k);
      e_s[k] = 1'b0;
      e_v[k] = 1'b0;
      if (v) begin
        if (s && m_idx[k] != 0) m_pr[k] = 1'b0;
        if (s) m_idx[k] = 0;
        j = m_idx[k];
        if (j < D) begin
          a_re[k][j] = xr; a_im[k][j] = xi;
          ore = d_re[k][j]; oim = d_im[k][j];
        end else begin
          ore = fmt(a_re[k][j-D] + xr, k);
          oim = fmt(a_im[k][j-D] + xi, k);
          d_re[k][j-D] = fmt(a_re[k][j-D] - xr, k);
          d_im[k][j-D] = fmt(a_im[k][j-D] - xi, k);
          m_pr[k] = 1'b1;
        end
        if (m_pr[k]) begin
          e_v[k] = 1'b1; e_s[k] = (j == D);
          e_re[k] = ore; e_im[k] = oim;
        end
        m_idx[k] = (j + 1) % (2 * D);
      end
    end
  endtask

  task automatic cmp_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("valid%0d", k), int'(o_v[k]), int'(e_v[k]));
      chk($sformatf("sync%0d", k), int'(o_s[k]), int'(e_s[k]));
      chk($sformatf("re%0d", k), int'($signed(o_re[k])), e_re[k]);
      chk($sformatf("im%0d", k), int'($signed(o_im[k])), e_im[k]);
    end
  endtask

  task automatic step(bit v, bit s, int re, int im);
    @(negedge clk);
    cmp_all();
    in_valid = v; in_sync = s;
    in_re = W'(re); in_im = W'(im);
    m_step(v, s, sx(re), sx(im));
  endtask

  task automatic areset();
    @(negedge clk);
    cmp_all();
    in_valid = 1'b0; in_sync = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_v%0d", k), int'(o_v[k]), 0);
      chk($sformatf("rst_s%0d", k), int'(o_s[k]), 0);
      chk($sformatf("rst_re%0d", k), int'(o_re[k]), 0);
      chk($sformatf("rst_im%0d", k), int'(o_im[k]), 0);
    end
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic ramp(bit stall);
    for (int f = 0; f < 2; f++)
      for (int i = 1; i <= 8; i++) begin
        step(1'b1, i == 1, i, 0);
        if (stall) step(1'b0, 1'b0, 99, 99);
      end
    step(1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Pairing on DEPTH=1.
    step(1'b1, 1'b1, 100, -5);
    step(1'b1, 1'b0, 20, 7);
    step(1'b1, 1'b0, 0, 0);
    chk("pair_sum_re", int'($signed(o_re[1])), 120);
    chk("pair_sum_im", int'($signed(o_im[1])), 2);
    chk("pair_sync", int'(o_s[1]), 1);
    step(1'b0, 1'b0, 0, 0);
    chk("pair_dif_re", int'($signed(o_re[1])), 80);
    chk("pair_dif_im", int'($signed(o_im[1])), -12);

    // Overflow on DEPTH=1.
    areset();
    step(1'b1, 1'b1, 65535, 0);
    step(1'b1, 1'b0, 1, 0);
    step(1'b1, 1'b0, 0, 0);
`ifdef BF2_SDF_SAT_EN
    chk("ovf_sum_s0", int'($signed(o_re[1])), 65535);
`else
    chk("ovf_sum_s0", int'($signed(o_re[1])), 0);
`endif
    chk("ovf_sum_s1", int'($signed(o_re[2])), 32768);
    step(1'b0, 1'b0, 0, 0);
    chk("ovf_dif_s0", int'($signed(o_re[1])), 65534);
    chk("ovf_dif_s1", int'($signed(o_re[2])), 32767);

    // Full frames, then stalled frames.
    areset();
    ramp(1'b0);
    areset();
    ramp(1'b1);

    // Mid-frame sync, then async reset mid-frame, then clean frames.
    areset();
    for (int i = 1; i <= 8; i++) step(1'b1, i == 1, i, 0);
    step(1'b1, 1'b1, 1, 1);
    step(1'b1, 1'b0, 2, 2);
    step(1'b1, 1'b1, 3, 3);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 10 * i, -i);
    areset();
    ramp(1'b0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) areset();
      else
        step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
             int'($urandom), int'($urandom));
    end
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
